// File: rtl/shift_rows_pipe_if.sv
// Valid/ready stream carrying a Rijndael state and its ShiftRows mode bit.
// The master drives valid/inv/state; the slave drives ready.
interface shift_rows_pipe_if #(
   parameter int unsigned NB = 4
) ();
   localparam int unsigned W = 32 * NB;

   logic         valid;
   logic         ready;
   logic         inv;
   logic [W-1:0] state;

   modport master (output valid, output inv, output state, input ready);
   modport slave (input valid, input inv, input state, output ready);
endinterface

// File: rtl/shift_rows_pipe.sv
// Pipelined, valid/ready Rijndael ShiftRows for NB = 4/6/8 columns.
// Define SHIFT_ROWS_INV_EN to build the per-transfer InvShiftRows option.
module shift_rows_pipe #(
   parameter int unsigned NB          = 4,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   shift_rows_pipe_if.slave  in_bus,
   shift_rows_pipe_if.master out_bus
);
   localparam int unsigned W    = 32 * NB;
   localparam int unsigned LAST = PIPE_STAGES - 1;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: PIPE_STAGES must be 1..4");
   end

   // Byte k = 4*c + r sits at [W-1-8k -: 8]; rows 2/3 shift one extra place for NB = 8.
   logic [W-1:0] fwd_state;
   logic [W-1:0] perm_state;

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int unsigned SH  = (NB == 8 && r >= 2) ? r + 1 : r;
         localparam int unsigned SRC = 4 * ((c + SH) % NB) + r;
         assign fwd_state[W-1-8*(4*c+r) -: 8] = in_bus.state[W-1-8*SRC -: 8];
      end
   end

`ifdef SHIFT_ROWS_INV_EN
   logic [W-1:0] inv_state;

   for (genvar c = 0; c < NB; c++) begin : g_icol
      for (genvar r = 0; r < 4; r++) begin : g_irow
         localparam int unsigned SH  = (NB == 8 && r >= 2) ? r + 1 : r;
         localparam int unsigned SRC = 4 * ((c + NB - SH) % NB) + r;
         assign inv_state[W-1-8*(4*c+r) -: 8] = in_bus.state[W-1-8*SRC -: 8];
      end
   end

   assign perm_state = in_bus.inv ? inv_state : fwd_state;
`else
   logic unused_in_inv;

   assign unused_in_inv = in_bus.inv;
   assign perm_state    = fwd_state;
`endif

   logic [PIPE_STAGES-1:0] valid_vec;
   logic [PIPE_STAGES-1:0] load;
   logic [W-1:0]           state_vec [PIPE_STAGES];
`ifdef SHIFT_ROWS_INV_EN
   logic [PIPE_STAGES-1:0] inv_vec;
`endif

   // A stage advances if it or any later stage is empty, or the consumer takes the tail.
   always_comb begin
      logic acc;
      acc  = out_bus.ready;
      load = '0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
         acc            = acc | ~valid_vec[LAST-i];
         load[LAST-i]   = acc;
      end
   end

   assign in_bus.ready = load[0] & ~flush;

   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      logic         src_valid;
      logic [W-1:0] src_state;
      logic         v_q;
      logic [W-1:0] st_q;

      if (k == 0) begin : g_src_in
         assign src_valid = in_bus.valid;
         assign src_state = perm_state;
      end else begin : g_src_prev
         assign src_valid = valid_vec[k-1];
         assign src_state = state_vec[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q  <= 1'b0;
            st_q <= '0;
         end else if (flush) begin
            v_q <= 1'b0;
         end else if (load[k]) begin
            v_q <= src_valid;
            if (src_valid) begin
               st_q <= src_state;
            end
         end
      end

      assign valid_vec[k] = v_q;
      assign state_vec[k] = st_q;

`ifdef SHIFT_ROWS_INV_EN
      logic src_inv;
      logic inv_q;

      if (k == 0) begin : g_inv_in
         assign src_inv = in_bus.inv;
      end else begin : g_inv_prev
         assign src_inv = inv_vec[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            inv_q <= 1'b0;
         end else if (!flush && load[k] && src_valid) begin
            inv_q <= src_inv;
         end
      end

      assign inv_vec[k] = inv_q;
`endif
   end

   assign out_bus.valid = valid_vec[LAST];
   assign out_bus.state = state_vec[LAST];
`ifdef SHIFT_ROWS_INV_EN
   assign out_bus.inv   = inv_vec[LAST];
`else
   assign out_bus.inv   = 1'b0;
`endif
endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle 128-bit ShiftRows register.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns and a configurable register-pipeline depth.
- Performs forward ShiftRows or, optionally, InvShiftRows, selected per transfer.
- Sits between SubBytes and MixColumns in the round datapath; valid/ready on both sides allows stalls from the key schedule or output drain.

Parameters:
- NB, 4, number of state columns (legal: 4, 6, 8); state width W = 32*NB.
- PIPE_STAGES, 2, number of register stages (legal 1..4); sets latency.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all pipeline valids.
- in_valid  input  1  input transfer request.
- in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the transfer.
- in_state  input  W  flattened state, column-major, byte k = 4*c + r at bits [W-1-8k -: 8].
- out_valid  output  1  output holds a result.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_state  output  W  transformed state.
- out_inv  output  1  mode the result was produced with.

Behaviour:
- Shift offsets per row r:
  - NB = 4 or 6: s = {0, 1, 2, 3}.
  - NB = 8: s = {0, 1, 3, 4}.
- Forward: out(r,c) = in(r, (c + s[r]) mod NB).
- Inverse: out(r,c) = in(r, (c - s[r]) mod NB).
- The permutation is combinational into stage 0. Stages 1..PIPE_STAGES-1 are plain registers carrying {state, inv, valid}.
- Stage advance rule:
  - The last stage loads when !v[last] || out_ready.
  - Stage k loads from k-1 when !v[k] || load[k+1].
  - in_ready = load[0]. This is combinational from out_ready, so bubbles collapse.
  - A stage that loads from an empty predecessor clears its valid.
- out_valid = v[last]. out_state and out_inv come from the last stage.
- Latency: PIPE_STAGES cycles from the input handshake to out_valid when out_ready stays high.
- Throughput: one transfer per cycle.
- Stall: when out_ready = 0 and all stages are valid, in_ready = 0. out_state, out_inv and out_valid stay stable until accepted.
- Simultaneous input and output handshakes on a full pipe are legal and sustain full rate.
- flush = 1: all v[] clear at the next edge and the in-cycle input is discarded. in_ready is forced 0 during flush. flush has priority over any handshake.
- Reset (rst high, asynchronous): all v[] = 0; all data and inv registers = 0.
  - Outputs during reset: out_valid = 0, out_state = 0, out_inv = 0.
  - in_ready = 1 once rst deasserts (pipeline empty).
  - Reset mid-stream discards all in-flight data.
- Data registers load only on stage advance. Non-advancing stages hold their value.
- Illegal NB or PIPE_STAGES: elaboration error via generate-time check.

Optional Feature:
- Macro: SHIFT_ROWS_INV_EN.
- Defined: in_inv selects the inverse permutation as described above.
- Undefined:
  - Only forward ShiftRows is built; in_inv is ignored.
  - out_inv is tied to 0.
  - No inverse mux logic is generated.

Test Plan:
- NB=4, PIPE_STAGES=2, forward, in_state = 0x000102030405060708090a0b0c0d0e0f, out_ready=1 -> two cycles later out_valid=1, out_state = 0x00050a0f04090e03080d02070c01060b.
- Same input with in_inv=1 (macro defined) -> out_state = 0x000d0a0704010e0b0805020f0c090603, out_inv=1. Feed that result back forward -> original 0x00..0f returned.
- NB=8, forward, byte k = k for k = 0..31 -> column 0 bytes 00 05 0e 13; column 7 bytes 1c 01 0a 0f. Inverse of that output restores the input.
- Back-to-back stream of 8 states with out_ready low for cycles 3..6:
  - in_ready drops once PIPE_STAGES entries are held.
  - All 8 outputs arrive in order, none dropped or duplicated, with out_state stable while stalled.
- Assert rst asynchronously mid-clock with 2 entries in flight -> out_valid=0 and out_state=0 immediately; no stale output after release.
- flush pulse with full pipe and in_valid=1 -> next cycle out_valid=0; the concurrent input is not emitted; the next transfer has normal latency.
